// File: rtl/traffic_light_monitor.sv
// Traffic light monitor: locks onto the observed lamp phase, tracks the RED->REDYLW->GREEN->YELLOW
// sequence and phase durations, and flags illegal codes, order violations and timing violations.
module traffic_light_monitor #(
  parameter int unsigned RED_T    = 20,
  parameter int unsigned REDYLW_T = 4,
  parameter int unsigned GREEN_T  = 20,
  parameter int unsigned YELLOW_T = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        red,
  input  logic        yellow,
  input  logic        green,
  output logic [1:0]  phase,
  output logic        locked,
  output logic        phase_start,
  output logic        err_illegal,
  output logic        err_order,
  output logic        err_duration,
  output logic [15:0] cycle_count,
  output logic [7:0]  err_count
);

  localparam int unsigned DUR_W = 8;
  localparam int unsigned CYC_W = 16;

  typedef enum logic {UNSYNC, TRACK} state_t;

  state_t             state_q, state_d;
  logic [1:0]         phase_d;
  logic               locked_d, phase_start_d;
  logic               err_illegal_d, err_order_d, err_duration_d;
  logic [CYC_W-1:0]   cycle_count_d;
  logic [7:0]         err_count_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic               first_q, first_d;

  logic               code_ok;
  logic [1:0]         code;
  logic [1:0]         succ;
  logic [DUR_W-1:0]   exp_len;

  // Lamp decode: {red,yellow,green}
  always_comb begin
    code_ok = 1'b1;
    code    = 2'd0;
    case ({red, yellow, green})
      3'b100:  code = 2'd0;
      3'b110:  code = 2'd1;
      3'b001:  code = 2'd2;
      3'b010:  code = 2'd3;
      default: code_ok = 1'b0;
    endcase
  end

  assign succ = phase + 2'd1;

  always_comb begin
    case (phase)
      2'd0:    exp_len = DUR_W'(RED_T);
      2'd1:    exp_len = DUR_W'(REDYLW_T);
      2'd2:    exp_len = DUR_W'(GREEN_T);
      default: exp_len = DUR_W'(YELLOW_T);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= UNSYNC;
      phase        <= 2'd0;
      locked       <= 1'b0;
      phase_start  <= 1'b0;
      err_illegal  <= 1'b0;
      err_order    <= 1'b0;
      err_duration <= 1'b0;
      cycle_count  <= '0;
      err_count    <= '0;
      dur_q        <= '0;
      first_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      phase        <= phase_d;
      locked       <= locked_d;
      phase_start  <= phase_start_d;
      err_illegal  <= err_illegal_d;
      err_order    <= err_order_d;
      err_duration <= err_duration_d;
      cycle_count  <= cycle_count_d;
      err_count    <= err_count_d;
      dur_q        <= dur_d;
      first_q      <= first_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d        = state_q;
    phase_d        = phase;
    locked_d       = locked;
    phase_start_d  = 1'b0;
    err_illegal_d  = 1'b0;
    err_order_d    = 1'b0;
    err_duration_d = 1'b0;
    cycle_count_d  = cycle_count;
    dur_d          = dur_q;
    first_d        = first_q;

    case (state_q)
      UNSYNC: begin
        if (code_ok) begin
          state_d       = TRACK;
          locked_d      = 1'b1;
          phase_d       = code;
          dur_d         = DUR_W'(1);
          first_d       = 1'b1;
          phase_start_d = 1'b1;
        end
      end
      TRACK: begin
        if (!code_ok) begin
          err_illegal_d = 1'b1;
          state_d       = UNSYNC;
          locked_d      = 1'b0;
        end else if (code == phase) begin
          // dur crosses exp_len only once, so an overrun is flagged once per phase
          if (!first_q && dur_q == exp_len) err_duration_d = 1'b1;
          if (dur_q != {DUR_W{1'b1}}) dur_d = dur_q + DUR_W'(1);
        end else if (code == succ) begin
          if (!first_q && dur_q < exp_len) err_duration_d = 1'b1;
          if (phase == 2'd3) cycle_count_d = cycle_count + CYC_W'(1);
          phase_d       = code;
          dur_d         = DUR_W'(1);
          first_d       = 1'b0;
          phase_start_d = 1'b1;
        end else begin
          err_order_d   = 1'b1;
          phase_d       = code;
          dur_d         = DUR_W'(1);
          first_d       = 1'b1;
          phase_start_d = 1'b1;
        end
      end
      default: state_d = UNSYNC;
    endcase

    err_count_d = err_count;
    if ((err_illegal_d || err_order_d || err_duration_d) && err_count != 8'hFF)
      err_count_d = err_count + 8'd1;
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: directed scenarios plus randomized lamp
// sequences, checked every cycle against a phase-rule reference model.
module tb_traffic_light_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        red, yellow, green;
  logic [1:0]  phase;
  logic        locked, phase_start, err_illegal, err_order, err_duration;
  logic [15:0] cycle_count;
  logic [7:0]  err_count;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit m_sync;
  int m_phase, m_dur, m_cyc, m_errc;
  bit m_first, m_ps, m_ei, m_eo, m_ed;

  traffic_light_monitor dut (
    .clk(clk), .rst(rst), .red(red), .yellow(yellow), .green(green),
    .phase(phase), .locked(locked), .phase_start(phase_start),
    .err_illegal(err_illegal), .err_order(err_order), .err_duration(err_duration),
    .cycle_count(cycle_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_len(input int p);
    case (p)
      0: return 20;
      1: return 4;
      2: return 20;
      default: return 4;
    endcase
  endfunction

  function automatic logic [2:0] lamps_of(input int p);
    case (p)
      0: return 3'b100;
      1: return 3'b110;
      2: return 3'b001;
      default: return 3'b010;
    endcase
  endfunction

  function automatic int decode(input logic [2:0] l);
    for (int p = 0; p < 4; p++)
      if (lamps_of(p) == l) return p;
    return -1;
  endfunction

  task automatic model_reset();
    m_sync = 0; m_phase = 0; m_dur = 0; m_first = 1; m_cyc = 0; m_errc = 0;
    m_ps = 0; m_ei = 0; m_eo = 0; m_ed = 0;
  endtask

  task automatic model_step(input logic [2:0] l);
    int c;
    c = decode(l);
    m_ps = 0; m_ei = 0; m_eo = 0; m_ed = 0;
    if (!m_sync) begin
      if (c >= 0) begin
        m_sync = 1; m_phase = c; m_dur = 1; m_first = 1; m_ps = 1;
      end
    end else if (c < 0) begin
      m_ei = 1; m_sync = 0;
    end else if (c == m_phase) begin
      if (!m_first && m_dur == exp_len(m_phase)) m_ed = 1;
      m_dur = (m_dur < 255) ? m_dur + 1 : 255;
    end else if (c == (m_phase + 1) % 4) begin
      if (!m_first && m_dur < exp_len(m_phase)) m_ed = 1;
      if (m_phase == 3) m_cyc = (m_cyc + 1) % 65536;
      m_ps = 1; m_phase = c; m_dur = 1; m_first = 0;
    end else begin
      m_eo = 1; m_ps = 1; m_phase = c; m_dur = 1; m_first = 1;
    end
    m_errc = m_errc + int'(m_ei) + int'(m_eo) + int'(m_ed);
    if (m_errc > 255) m_errc = 255;
  endtask

  task automatic compare_all(input string where);
    check({where, ".phase"},        int'(phase),        m_phase);
    check({where, ".locked"},       int'(locked),       int'(m_sync));
    check({where, ".phase_start"},  int'(phase_start),  int'(m_ps));
    check({where, ".err_illegal"},  int'(err_illegal),  int'(m_ei));
    check({where, ".err_order"},    int'(err_order),    int'(m_eo));
    check({where, ".err_duration"}, int'(err_duration), int'(m_ed));
    check({where, ".cycle_count"},  int'(cycle_count),  m_cyc);
    check({where, ".err_count"},    int'(err_count),    m_errc);
  endtask

  // Drive one lamp sample, then check outputs just after the capturing edge
  task automatic drive(input logic [2:0] l, input string where);
    {red, yellow, green} = l;
    @(posedge clk);
    #1;
    model_step(l);
    compare_all(where);
  endtask

  task automatic drive_phase(input int p, input int n, input string where);
    for (int i = 0; i < n; i++) drive(lamps_of(p), where);
  endtask

  // Assert reset between edges and check the outputs clear without a clock
  task automatic reset_mid(input string where);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check({where, ".rst_phase"}, int'(phase), 0);
    check({where, ".rst_locked"}, int'(locked), 0);
    check({where, ".rst_errs"}, int'({phase_start, err_illegal, err_order, err_duration}), 0);
    check({where, ".rst_cycle_count"}, int'(cycle_count), 0);
    check({where, ".rst_err_count"}, int'(err_count), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    compare_all({where, ".post_rst"});
  endtask

  initial begin
    int p, left, r;
    rst = 1'b1;
    {red, yellow, green} = 3'b000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    rst = 1'b0;

    // Nominal light for 500 cycles
    for (int k = 0; k < 10; k++)
      for (int q = 0; q < 4; q++) drive_phase(q, exp_len(q), "nominal");
    drive_phase(0, 20, "nominal");
    check("nominal.err_count", int'(err_count), 0);
    check("nominal.cycle_count", int'(cycle_count), 10);

    // GREEN overrun: pulse on 21st sample only
    drive_phase(1, 4, "overrun");
    drive_phase(2, 20, "overrun");
    check("overrun.no_early", int'(err_duration), 0);
    drive(lamps_of(2), "overrun");
    check("overrun.pulse", int'(err_duration), 1);
    drive_phase(2, 5, "overrun");
    check("overrun.once", int'(err_count), 1);

    // Short GREEN: pulse on first YELLOW sample
    drive_phase(3, 4, "short");
    drive_phase(0, 20, "short");
    drive_phase(1, 4, "short");
    drive_phase(2, 15, "short");
    drive(lamps_of(3), "short");
    check("short.err_duration", int'(err_duration), 1);
    check("short.phase", int'(phase), 3);
    drive_phase(3, 3, "short");

    // Out-of-order RED->GREEN, following long GREEN unchecked
    drive_phase(0, 5, "order");
    drive(lamps_of(2), "order");
    check("order.err_order", int'(err_order), 1);
    check("order.phase", int'(phase), 2);
    drive_phase(2, 30, "order");
    drive_phase(3, 4, "order");
    check("order.err_count", int'(err_count), 3);

    // Illegal code then relock on RED, that RED unchecked
    drive_phase(0, 10, "illegal");
    drive(3'b111, "illegal");
    check("illegal.pulse", int'(err_illegal), 1);
    check("illegal.locked", int'(locked), 0);
    drive(lamps_of(0), "illegal");
    check("illegal.relock", int'(locked), 1);
    check("illegal.relock_phase", int'(phase), 0);
    drive_phase(0, 30, "illegal");
    check("illegal.err_count", int'(err_count), 4);

    // 300 forced errors saturate err_count
    for (int i = 0; i < 300; i++) begin
      drive(3'b111, "sat");
      drive(lamps_of(0), "sat");
    end
    check("sat.err_count", int'(err_count), 255);

    drive_phase(0, 5, "midrst");
    reset_mid("midrst");

    // Randomized near-nominal light with glitches, jumps and resets
    p = 0; left = 0;
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 3) begin
        reset_mid("rand");
      end else if (r < 50) begin
        drive(3'($urandom_range(0, 7)), "rand");
      end else if (r < 70) begin
        p = int'($urandom_range(0, 3));
        left = exp_len(p);
        drive(lamps_of(p), "rand");
      end else begin
        if (left <= 0) begin
          p = (p + 1) % 4;
          left = exp_len(p) + int'($urandom_range(0, 4)) - 2;
        end
        drive(lamps_of(p), "rand");
        left--;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter RED_T, default 20, expected RED phase length in cycles (legal range 1..254).
REQ-002 Parameter REDYLW_T, default 4, expected RED+YELLOW phase length in cycles (legal range 1..254).
REQ-003 Parameter GREEN_T, default 20, expected GREEN phase length in cycles (legal range 1..254).
REQ-004 Parameter YELLOW_T, default 4, expected YELLOW phase length in cycles (legal range 1..254).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 red  input  1  observed red lamp.
REQ-008 yellow  input  1  observed yellow lamp.
REQ-009 green  input  1  observed green lamp.
REQ-010 phase  output  2  tracked phase: 0=RED, 1=REDYLW, 2=GREEN, 3=YELLOW.
REQ-011 locked  output  1  high while a legal phase is being tracked.
REQ-012 phase_start  output  1  one-cycle pulse when a new tracked phase begins.
REQ-013 err_illegal  output  1  one-cycle pulse: illegal lamp combination sampled.
REQ-014 err_order  output  1  one-cycle pulse: legal phase change out of sequence.
REQ-015 err_duration  output  1  one-cycle pulse: phase too short or too long.
REQ-016 cycle_count  output  16  count of YELLOW->RED transitions, wraps at 65535->0.
REQ-017 err_count  output  8  total error pulses, saturates at 255.

Function
REQ-018 Lamps {red,yellow,green} SHALL decode as: 100=RED, 110=REDYLW, 001=GREEN, 010=YELLOW; all other codes illegal.
REQ-019 All outputs SHALL be registered; an input sampled at edge N SHALL be reflected on outputs after edge N (one-cycle latency).
REQ-020 FSM states SHALL be UNSYNC and TRACK; reset enters UNSYNC.
REQ-021 UNSYNC + legal code: go TRACK, phase<=code, dur<=1, first<=1, phase_start pulse; no error checks.
REQ-022 UNSYNC + illegal code: stay UNSYNC, no err_illegal pulse (lamps unknown before lock).
REQ-023 TRACK + illegal code: err_illegal pulse, go UNSYNC, locked<=0; no other error that cycle.
REQ-024 TRACK + same code: dur increments, saturating at 255.
REQ-025 TRACK + same code with dur==expected(phase) and first==0: err_duration pulse (overrun, once per phase since dur passes expected once).
REQ-026 Legal successor order SHALL be RED->REDYLW->GREEN->YELLOW->RED.
REQ-027 TRACK + different legal code that is the successor: phase_start pulse, phase<=code, dur<=1, first<=0; err_duration pulse iff first==0 and dur<expected(old phase).
REQ-028 TRACK + different legal code that is not the successor: err_order pulse, phase_start pulse, adopt code, dur<=1, first<=1 (completed and new phase durations unchecked).
REQ-029 cycle_count SHALL increment on each legal YELLOW->RED successor transition.
REQ-030 err_count SHALL add the number of error pulses asserted that cycle (0..1, errors are mutually exclusive per cycle) and saturate at 255.
REQ-031 Internal dur counter SHALL be 8 bits; expected values compared as 8-bit unsigned.

Reset
REQ-032 rst high SHALL immediately force: state UNSYNC, phase=0, locked=0, phase_start=0, all err_*=0, cycle_count=0, err_count=0, dur=0, first=1.
REQ-033 Reset mid-phase SHALL discard tracking; after release the first legal phase is unchecked per REQ-021.

Verification
REQ-034 Drive with default-parameter traffic_light, 500 cycles after reset -> err_count=0, cycle_count increments every 48 cycles, phase follows 0,1,2,3.
REQ-035 After lock, hold GREEN for 21 cycles (GREEN_T=20) -> err_duration pulses on the 21st GREEN sample, exactly once.
REQ-036 After lock, GREEN for 15 cycles then YELLOW -> err_duration pulse on first YELLOW sample, phase=3.
REQ-037 While tracking RED, drive GREEN -> err_order pulse, phase=2, following GREEN length unchecked.
REQ-038 While tracking, drive 111 for 1 cycle then RED -> err_illegal pulse, locked=0 one cycle, relock with phase=0, no err_duration for that RED.
REQ-039 Force 300 errors -> err_count saturates at 255; assert rst mid-phase -> all outputs 0 asynchronously.
